vec_reg_file_sb: RTL
====================

Name: vec_reg_file_sb

Overview:
Parametrised successor to the scalar register file for the SIMD decode stage.
- Stores REG_COUNT vector registers of LANES x LANE_W bits.
- Two combinational read ports and one write port with per-lane write mask.
- Built-in scoreboard tracks registers with an in-flight producer and flags read-after-write hazards, so decode can stall issue.

Parameters:
- LANES, 4, number of SIMD lanes per register.
- LANE_W, 32, bits per lane; register width REG_W = LANES*LANE_W.
- REG_COUNT, 16, number of vector registers.
- SEL_BITS, 4, register select width; must satisfy 2**SEL_BITS >= REG_COUNT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- regWrEn  input  1  writeback strobe.
- regToWrite  input  SEL_BITS  writeback destination register.
- laneMask  input  LANES  per-lane write enable; bit i covers lane i = dataIn[i*LANE_W +: LANE_W].
- dataIn  input  REG_W  writeback data.
- rSel1, rSel2  input  SEL_BITS  read selects.
- operand1, operand2  output  REG_W  read data.
- issueEn  input  1  decode issues an instruction that will write issueDest.
- issueDest  input  SEL_BITS  destination register of the issued instruction.
- busy1, busy2  output  1  the selected source still has a pending producer.
- stall  output  1  busy1 | busy2.
- busyVec  output  REG_COUNT  raw scoreboard bits.

Behaviour:
- Reset (reset=0, async):
  - All registers clear to 0.
  - busyVec clears to 0.
  - operand1/operand2 therefore read 0; busy1, busy2 and stall read 0.
  - Reset asserted mid-operation discards pending writes and scoreboard state immediately, without waiting for clk.
- Write (rising clk, regWrEn=1):
  - For each lane i with laneMask[i]=1, lane i of reg[regToWrite] <= lane i of dataIn.
  - Lanes with laneMask[i]=0 keep their old value.
  - laneMask = 0 writes nothing but still clears the busy bit (see scoreboard rules).
  - regToWrite >= REG_COUNT: write ignored; no busy bit affected.
- Read: combinational.
  - operandN = reg[rSelN]; latency 0.
  - rSelN >= REG_COUNT returns 0.
- Scoreboard, on rising clk, per register r:
  - set_r = issueEn & (issueDest==r).
  - clr_r = regWrEn & (regToWrite==r).
  - busy[r] <= set_r ? 1 : (clr_r ? 0 : busy[r]).
  - When a register is issued and written back in the same cycle, set wins: a new producer supersedes the completing one.
  - Issuing to an already-busy register keeps it busy (single outstanding producer per register; the issue stage enforces WAW ordering).
  - issueDest >= REG_COUNT is ignored.
- Hazard outputs (combinational):
  - busyN = busyVec[rSelN] & ~(regWrEn & regToWrite==rSelN & bypass_ok).
  - bypass_ok = 1 only when REGFILE_BYPASS_EN is defined and laneMask is all ones; otherwise bypass_ok = 0.
  - stall = busy1 | busy2.
  - rSelN >= REG_COUNT gives busyN = 0.
- Multiple reads of the same register on both ports are legal and return identical data.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding is active.
  - If regWrEn=1 and regToWrite==rSelN in the same cycle, operandN presents the merged value: dataIn lanes where laneMask=1, stored lanes elsewhere.
  - With a full laneMask, busyN is suppressed for that port (the consumer may issue this cycle).
- Undefined:
  - operandN shows the pre-write stored value until the next cycle.
  - busyN stays asserted until the clearing edge has passed.

Test Plan:
1. Reset low for 2 cycles, then high -> all operands 0, busyVec=0, stall=0; write reg3=0x44443333_22221111_..., then assert reset asynchronously mid-cycle -> operand reading r3 drops to 0 before the next clk edge.
2. Lane masking: reg5=0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD; write dataIn=all 0x11111111 with laneMask=4'b0101 -> reg5 reads 0xAAAAAAAA_11111111_CCCCCCCC_11111111.
3. Scoreboard: issueEn with issueDest=7; next cycle rSel1=7 -> busy1=1, stall=1; writeback reg7 with full mask -> busy1=0 the cycle after (same cycle if REGFILE_BYPASS_EN is defined).
4. Simultaneous events: busy[2]=1; in one cycle issueEn/issueDest=2 and regWrEn/regToWrite=2 -> busyVec[2] stays 1 and data is written.
5. Bypass (REGFILE_BYPASS_EN defined): reg9=0; regWrEn, regToWrite=9, dataIn=0x...DEADBEEF with full mask, rSel2=9 -> operand2=dataIn in the same cycle; with the macro undefined -> operand2=0 that cycle and dataIn next cycle.
6. Out-of-range handling (REG_COUNT=12, SEL_BITS=4): write to regToWrite=14 -> no register changes; rSel1=14 -> operand1=0, busy1=0.

Source files
------------

// File: rtl/vec_reg_file_sb_if.sv
// Bus bundle for vec_reg_file_sb: writeback, read, issue and hazard signals.
// Decode/writeback logic uses the master modport; the register file uses slave.
interface vec_reg_file_sb_if #(
    parameter int LANES     = 4,
    parameter int LANE_W    = 32,
    parameter int REG_COUNT = 16,
    parameter int SEL_BITS  = 4
);
    localparam int REG_W = LANES * LANE_W;

    logic                 regWrEn;
    logic [SEL_BITS-1:0]  regToWrite;
    logic [LANES-1:0]     laneMask;
    logic [REG_W-1:0]     dataIn;
    logic [SEL_BITS-1:0]  rSel1;
    logic [SEL_BITS-1:0]  rSel2;
    logic [REG_W-1:0]     operand1;
    logic [REG_W-1:0]     operand2;
    logic                 issueEn;
    logic [SEL_BITS-1:0]  issueDest;
    logic                 busy1;
    logic                 busy2;
    logic                 stall;
    logic [REG_COUNT-1:0] busyVec;

    modport master (
        output regWrEn, regToWrite, laneMask, dataIn, rSel1, rSel2, issueEn, issueDest,
        input  operand1, operand2, busy1, busy2, stall, busyVec
    );

    modport slave (
        input  regWrEn, regToWrite, laneMask, dataIn, rSel1, rSel2, issueEn, issueDest,
        output operand1, operand2, busy1, busy2, stall, busyVec
    );
endinterface

// File: rtl/vec_reg_file_sb.sv
// Vector register file (LANES x LANE_W per register) with per-lane write mask and
// a RAW scoreboard; define REGFILE_BYPASS_EN to forward writeback data to the read ports.
module vec_reg_file_sb #(
    parameter int LANES     = 4,
    parameter int LANE_W    = 32,
    parameter int REG_COUNT = 16,
    parameter int SEL_BITS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    vec_reg_file_sb_if.slave  rf
);
    localparam int REG_W = LANES * LANE_W;
    localparam logic [SEL_BITS:0] REG_LIMIT = (SEL_BITS + 1)'(REG_COUNT);

    logic [REG_W-1:0]     regs [REG_COUNT];
    logic [REG_COUNT-1:0] busyQ;
    logic                 wrValid;
    logic                 issueValid;
    logic                 bypassOk;
    logic [REG_W-1:0]     wrStored;
    logic [REG_W-1:0]     wrMerged;
    logic [REG_W-1:0]     stored1;
    logic [REG_W-1:0]     stored2;
    logic                 hit1;
    logic                 hit2;
    logic                 sel1Ok;
    logic                 sel2Ok;

    function automatic logic selValid(input logic [SEL_BITS-1:0] sel);
        return {1'b0, sel} < REG_LIMIT;
    endfunction

    function automatic logic [REG_W-1:0] mergeLanes(input logic [REG_W-1:0] oldVal,
                                                    input logic [REG_W-1:0] newVal,
                                                    input logic [LANES-1:0] mask);
        logic [REG_W-1:0] res;
        res = oldVal;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) res[i*LANE_W +: LANE_W] = newVal[i*LANE_W +: LANE_W];
        end
        return res;
    endfunction

    assign wrValid    = rf.regWrEn & selValid(rf.regToWrite);
    assign issueValid = rf.issueEn & selValid(rf.issueDest);
    assign wrStored   = wrValid ? regs[rf.regToWrite] : '0;
    assign wrMerged   = mergeLanes(wrStored, rf.dataIn, rf.laneMask);

`ifdef REGFILE_BYPASS_EN
    // Only a full-width write completes the producer for a same-cycle consumer.
    assign bypassOk = &rf.laneMask;
`else
    assign bypassOk = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
        end else if (wrValid) begin
            regs[rf.regToWrite] <= wrMerged;
        end
    end

    // Set beats clear: a newly issued producer supersedes one completing this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busyQ <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (issueValid && (rf.issueDest == SEL_BITS'(r))) begin
                    busyQ[r] <= 1'b1;
                end else if (wrValid && (rf.regToWrite == SEL_BITS'(r))) begin
                    busyQ[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel1Ok  = selValid(rf.rSel1);
        sel2Ok  = selValid(rf.rSel2);
        stored1 = sel1Ok ? regs[rf.rSel1] : '0;
        stored2 = sel2Ok ? regs[rf.rSel2] : '0;
        hit1    = wrValid && (rf.regToWrite == rf.rSel1);
        hit2    = wrValid && (rf.regToWrite == rf.rSel2);
    end

`ifdef REGFILE_BYPASS_EN
    assign rf.operand1 = hit1 ? wrMerged : stored1;
    assign rf.operand2 = hit2 ? wrMerged : stored2;
`else
    assign rf.operand1 = stored1;
    assign rf.operand2 = stored2;
`endif

    assign rf.busy1   = sel1Ok && busyQ[rf.rSel1] && !(hit1 && bypassOk);
    assign rf.busy2   = sel2Ok && busyQ[rf.rSel2] && !(hit2 && bypassOk);
    assign rf.stall   = rf.busy1 | rf.busy2;
    assign rf.busyVec = busyQ;
endmodule
